// File: rtl/nes_pad_pkg.sv
// Shared definitions for the NES pad scanner: button bit positions and FSM state encoding.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package nes_pad_pkg;

    // Bit positions within a button word, in controller shift order.
    localparam int BTN_A      = 0;
    localparam int BTN_B      = 1;
    localparam int BTN_SELECT = 2;
    localparam int BTN_START  = 3;
    localparam int BTN_UP     = 4;
    localparam int BTN_DOWN   = 5;
    localparam int BTN_LEFT   = 6;
    localparam int BTN_RIGHT  = 7;

    typedef enum logic [2:0] {
        IDLE,
        LATCH,
        SETTLE,
        CLK_HI,
        CLK_LO,
        DONE
    } pad_scan_state_t;

endpackage

// File: rtl/pad_sync2.sv
// Two-flop synchronizer for one asynchronous pad data bit; resets to 1 (released line).
// Latency: 2 clk cycles from input change to sync_out.
// Backpressure: none, samples every cycle.
//
// Ports: clk, rst_n (synchronous, active-low), async_in (raw pin), sync_out (synchronized).
module pad_sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic sync_out
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= async_in;
            sync_q <= meta_q;
        end
    end

    assign sync_out = sync_q;

endmodule

// File: rtl/pad_scanner.sv
// Scans two NES controllers (shared latch, per-port clock/data) and presents active-high button words.
// Latency: a scan spans 2*NBITS*HALF_CYC+1 cycles from start to the valid pulse; starts on scan_req or poll tick.
// Backpressure: none; a start while busy queues one pending scan, further starts are dropped.
//
// Ports: clk, rst_n (synchronous, active-low), scan_req (start pulse), pad_data[1:0] (raw, active-low),
//        pad_latch, pad_clk[1:0] (active-high pulses), btns0/btns1 (active-high words), busy, valid.
// Optional: define PAD_DEBOUNCE_EN to update a port only when two consecutive scans agree.
module pad_scanner #(
    parameter int HALF_CYC = 300,
    parameter int POLL_CYC = 833333,
    parameter int NBITS    = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             scan_req,
    input  logic [1:0]       pad_data,
    output logic             pad_latch,
    output logic [1:0]       pad_clk,
    output logic [NBITS-1:0] btns0,
    output logic [NBITS-1:0] btns1,
    output logic             busy,
    output logic             valid
);

    import nes_pad_pkg::*;

    localparam int PH_W   = (HALF_CYC > 1) ? $clog2(HALF_CYC) : 1;
    localparam int POLL_W = (POLL_CYC > 1) ? $clog2(POLL_CYC) : 1;
    localparam int IDX_W  = (NBITS > 1)    ? $clog2(NBITS)    : 1;

    localparam logic [PH_W-1:0]   PH_LAST   = PH_W'(HALF_CYC - 1);
    localparam logic [POLL_W-1:0] POLL_LAST = POLL_W'((POLL_CYC > 0) ? POLL_CYC - 1 : 0);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NBITS - 1);
    localparam bit                POLL_EN   = (POLL_CYC != 0);

    // Synchronized pad data, one synchronizer per port.
    logic [1:0] pad_sync;

    for (genvar p = 0; p < 2; p++) begin : g_sync
        pad_sync2 u_sync (
            .clk      (clk),
            .rst_n    (rst_n),
            .async_in (pad_data[p]),
            .sync_out (pad_sync[p])
        );
    end

    pad_scan_state_t   state_q,     state_d;
    logic [PH_W-1:0]   phase_q,     phase_d;
    logic [POLL_W-1:0] poll_q,      poll_d;
    logic [IDX_W-1:0]  idx_q,       idx_d;
    logic              pending_q,   pending_d;
    logic [NBITS-1:0]  sh0_q,       sh0_d;
    logic [NBITS-1:0]  sh1_q,       sh1_d;
    logic [NBITS-1:0]  btns0_q,     btns0_d;
    logic [NBITS-1:0]  btns1_q,     btns1_d;
    logic              valid_q,     valid_d;
    logic              busy_q,      busy_d;
    logic              pad_latch_q, pad_latch_d;
    logic [1:0]        pad_clk_q,   pad_clk_d;
`ifdef PAD_DEBOUNCE_EN
    logic [NBITS-1:0]  prev0_q,     prev0_d;
    logic [NBITS-1:0]  prev1_q,     prev1_d;
    logic              upd0,        upd1;
`endif

    logic poll_tick;
    logic start;
    logic ph_last;

    assign poll_tick = POLL_EN && (poll_q == POLL_LAST);
    assign start     = scan_req | poll_tick;
    assign ph_last   = (phase_q == PH_LAST);

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        pending_d = pending_q;
        sh0_d     = sh0_q;
        sh1_d     = sh1_q;
        btns0_d   = btns0_q;
        btns1_d   = btns1_q;
        valid_d   = 1'b0;
`ifdef PAD_DEBOUNCE_EN
        prev0_d   = prev0_q;
        prev1_d   = prev1_q;
        upd0      = 1'b0;
        upd1      = 1'b0;
`endif

        poll_d = POLL_EN ? (poll_tick ? '0 : poll_q + POLL_W'(1)) : '0;

        // DONE consumes any start itself, so only the mid-scan states queue one.
        if (start && state_q != IDLE && state_q != DONE) begin
            pending_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (start || pending_q) begin
                    state_d = LATCH;
                end
            end
            LATCH: begin
                if (ph_last) begin
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                if (ph_last) begin
                    // Bit 0 is already on the data line once the latch drops.
                    sh0_d[BTN_A] = pad_sync[0];
                    sh1_d[BTN_A] = pad_sync[1];
                    idx_d        = IDX_W'(1);
                    state_d      = (NBITS == 1) ? DONE : CLK_HI;
                end
            end
            CLK_HI: begin
                if (ph_last) begin
                    state_d = CLK_LO;
                end
            end
            CLK_LO: begin
                if (ph_last) begin
                    sh0_d[idx_q] = pad_sync[0];
                    sh1_d[idx_q] = pad_sync[1];
                    if (idx_q == IDX_LAST) begin
                        state_d = DONE;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = CLK_HI;
                    end
                end
            end
            DONE: begin
                pending_d = 1'b0;
                state_d   = (pending_q || start) ? LATCH : IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Phase counter restarts at every state entry, including CLK_LO -> CLK_HI.
        phase_d = (state_d != state_q || state_q == IDLE) ? '0 : phase_q + PH_W'(1);

        // Publish on entry to DONE so btns and valid line up with the DONE cycle.
        if (state_d == DONE) begin
`ifdef PAD_DEBOUNCE_EN
            upd0    = (sh0_d == prev0_q);
            upd1    = (sh1_d == prev1_q);
            prev0_d = sh0_d;
            prev1_d = sh1_d;
            if (upd0) begin
                btns0_d = ~sh0_d;
            end
            if (upd1) begin
                btns1_d = ~sh1_d;
            end
            valid_d = upd0 | upd1;
`else
            btns0_d = ~sh0_d;
            btns1_d = ~sh1_d;
            valid_d = 1'b1;
`endif
        end

        pad_latch_d = (state_d == LATCH);
        pad_clk_d   = (state_d == CLK_HI) ? 2'b11 : 2'b00;
        busy_d      = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            phase_q     <= '0;
            poll_q      <= '0;
            idx_q       <= '0;
            pending_q   <= 1'b0;
            sh0_q       <= '1;
            sh1_q       <= '1;
            btns0_q     <= '0;
            btns1_q     <= '0;
            valid_q     <= 1'b0;
            busy_q      <= 1'b0;
            pad_latch_q <= 1'b0;
            pad_clk_q   <= 2'b00;
`ifdef PAD_DEBOUNCE_EN
            prev0_q     <= '1;
            prev1_q     <= '1;
`endif
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            poll_q      <= poll_d;
            idx_q       <= idx_d;
            pending_q   <= pending_d;
            sh0_q       <= sh0_d;
            sh1_q       <= sh1_d;
            btns0_q     <= btns0_d;
            btns1_q     <= btns1_d;
            valid_q     <= valid_d;
            busy_q      <= busy_d;
            pad_latch_q <= pad_latch_d;
            pad_clk_q   <= pad_clk_d;
`ifdef PAD_DEBOUNCE_EN
            prev0_q     <= prev0_d;
            prev1_q     <= prev1_d;
`endif
        end
    end

    assign pad_latch = pad_latch_q;
    assign pad_clk   = pad_clk_q;
    assign btns0     = btns0_q;
    assign btns1     = btns1_q;
    assign busy      = busy_q;
    assign valid     = valid_q;

endmodule

// File: tb/tb_pad_scanner.sv
// Directed bench for pad_scanner with a behavioural two-port NES pad model.
// Latency: n/a (testbench).
// Backpressure: n/a.
module tb_pad_scanner;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rst_n_p = 1'b0;
    logic       scan_req = 1'b0;
    logic [1:0] pad_data;
    logic       pad_latch;
    logic [1:0] pad_clk;
    logic [7:0] btns0, btns1;
    logic       busy, valid;

    logic [1:0] pad_data_p;
    logic       pad_latch_p;
    logic [1:0] pad_clk_p;
    logic [7:0] btns0_p, btns1_p;
    logic       busy_p, valid_p;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    // Pad model: latch reloads the snapshot, each pad_clk rise shifts the next bit out.
    logic [7:0] snap0 = 8'hFF;
    logic [7:0] snap1 = 8'hFF;
    logic [7:0] sr0 = 8'hFF;
    logic [7:0] sr1 = 8'hFF;
    logic       pclk_prev = 1'b0;
    logic       disc = 1'b0;

    always @(posedge clk) begin
        pclk_prev <= pad_clk[0];
        if (pad_latch) begin
            sr0 <= snap0;
            sr1 <= snap1;
        end else if (pad_clk[0] && !pclk_prev) begin
            sr0 <= {1'b1, sr0[7:1]};
            sr1 <= {1'b1, sr1[7:1]};
        end
    end

    assign pad_data   = disc ? 2'b11 : {sr1[0], sr0[0]};
    assign pad_data_p = 2'b11;

    pad_scanner #(.HALF_CYC(4), .POLL_CYC(0), .NBITS(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .scan_req  (scan_req),
        .pad_data  (pad_data),
        .pad_latch (pad_latch),
        .pad_clk   (pad_clk),
        .btns0     (btns0),
        .btns1     (btns1),
        .busy      (busy),
        .valid     (valid)
    );

    pad_scanner #(.HALF_CYC(4), .POLL_CYC(200), .NBITS(8)) dut_poll (
        .clk       (clk),
        .rst_n     (rst_n_p),
        .scan_req  (1'b0),
        .pad_data  (pad_data_p),
        .pad_latch (pad_latch_p),
        .pad_clk   (pad_clk_p),
        .btns0     (btns0_p),
        .btns1     (btns1_p),
        .busy      (busy_p),
        .valid     (valid_p)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Leaves the bench sampling the DONE cycle (64 edges after the start edge).
    task automatic scan_to_done();
        scan_req = 1'b1;
        tick();
        scan_req = 1'b0;
        repeat (64) tick();
    endtask

    initial begin
        int nb;
        int nv;
        int rises;
        logic gap;
        logic prev_l;

        // Reset state
        repeat (3) tick();
        check("rst_latch", pad_latch, 0);
        check("rst_clk", pad_clk, 0);
        check("rst_busy", busy, 0);
        check("rst_valid", valid, 0);
        check("rst_btns", {btns1, btns0}, 0);

        // Test 3: auto-poll every 200 cycles after reset release
        rst_n   = 1'b1;
        rst_n_p = 1'b1;
        rises   = 0;
        prev_l  = 1'b0;
        for (int n = 1; n <= 600; n++) begin
            tick();
            if (pad_latch_p && !prev_l) rises++;
            prev_l = pad_latch_p;
            if (n == 199) check("poll_199", pad_latch_p, 0);
            if (n == 200) check("poll_200", pad_latch_p, 1);
            if (n == 264) check("poll_done_valid", valid_p, 1);
            if (n == 264) check("poll_done_btns", {btns1_p, btns0_p}, 0);
            if (n == 399) check("poll_399", pad_latch_p, 0);
            if (n == 400) check("poll_400", pad_latch_p, 1);
            if (n == 600) check("poll_600", pad_latch_p, 1);
        end
        check("poll_rises", rises, 3);
        check("idle_no_poll", busy, 0);

        // Test 1: single scan, port0 A+Start, port1 nothing
        snap0 = 8'b11110110;
        snap1 = 8'b11111111;
`ifdef PAD_DEBOUNCE_EN
        scan_to_done();
        tick();
`endif
        scan_req = 1'b1;
        tick();
        scan_req = 1'b0;
        check("t1_latch_first", pad_latch, 1);
        nb = busy ? 1 : 0;
        nv = valid ? 1 : 0;
        for (int t = 1; t <= 80; t++) begin
            tick();
            nb += busy ? 1 : 0;
            nv += valid ? 1 : 0;
            if (t == 63) check("t1_btns_hold", btns0, 8'h00);
            if (t == 64) check("t1_valid", valid, 1);
            if (t == 64) check("t1_btns0", btns0, 8'h09);
            if (t == 64) check("t1_btns1", btns1, 8'h00);
        end
        check("t1_busy_cycles", nb, 65);
        check("t1_valid_count", nv, 1);

        // Test 2: starts while busy queue exactly one back-to-back scan
        scan_req = 1'b1;
        tick();
        scan_req = 1'b0;
        nv  = 0;
        gap = 1'b0;
        for (int t = 1; t <= 140; t++) begin
            scan_req = (t == 10 || t == 20 || t == 30 || t == 40);
            tick();
            scan_req = 1'b0;
            nv += valid ? 1 : 0;
            if (t <= 129 && !busy) gap = 1'b1;
            if (t == 64) check("t2_valid1", valid, 1);
            if (t == 65) check("t2_relatch", {busy, pad_latch}, 2'b11);
            if (t == 129) check("t2_valid2", valid, 1);
            if (t == 130) check("t2_idle", busy, 0);
        end
        check("t2_no_gap", gap, 0);
        check("t2_valid_count", nv, 2);
        check("t2_btns0", btns0, 8'h09);

        // Test 6: disconnected pads read as no buttons, valid still pulses
        disc = 1'b1;
`ifdef PAD_DEBOUNCE_EN
        scan_to_done();
        tick();
`endif
        scan_to_done();
        check("t6_valid", valid, 1);
        check("t6_btns", {btns1, btns0}, 16'h0000);
        tick();
        disc = 1'b0;

        // Test 5: FE, 00, 00 on successive scans (both ports)
        snap0 = 8'hFE;
        snap1 = 8'hFE;
        scan_to_done();
`ifdef PAD_DEBOUNCE_EN
        check("t5_s1_valid", valid, 0);
        check("t5_s1_btns0", btns0, 8'h00);
`else
        check("t5_s1_valid", valid, 1);
        check("t5_s1_btns0", btns0, 8'h01);
        check("t5_s1_btns1", btns1, 8'h01);
`endif
        tick();
        snap0 = 8'h00;
        snap1 = 8'h00;
        scan_to_done();
`ifdef PAD_DEBOUNCE_EN
        check("t5_s2_valid", valid, 0);
        check("t5_s2_btns0", btns0, 8'h00);
`else
        check("t5_s2_valid", valid, 1);
        check("t5_s2_btns0", btns0, 8'hFF);
`endif
        tick();
        scan_to_done();
        check("t5_s3_valid", valid, 1);
        check("t5_s3_btns0", btns0, 8'hFF);
        check("t5_s3_btns1", btns1, 8'hFF);
        tick();

        // Test 4: reset during CLK_LO of bit 3 discards the scan
        snap0 = 8'b11110110;
        snap1 = 8'b11111111;
        scan_req = 1'b1;
        tick();
        scan_req = 1'b0;
        repeat (27) tick();
        check("t4_clk_hi_b3", pad_clk, 2'b11);
        repeat (2) tick();
        check("t4_clk_lo_b3", {busy, pad_clk}, 3'b100);
        rst_n = 1'b0;
        tick();
        check("t4_rst_clk", pad_clk, 0);
        check("t4_rst_latch", pad_latch, 0);
        check("t4_rst_busy", busy, 0);
        check("t4_rst_btns", {btns1, btns0}, 0);
        check("t4_rst_valid", valid, 0);
        rst_n = 1'b1;
        nv = 0;
        nb = 0;
        for (int t = 0; t < 100; t++) begin
            tick();
            nv += valid ? 1 : 0;
            nb += busy ? 1 : 0;
        end
        check("t4_no_valid", nv, 0);
        check("t4_stays_idle", nb, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
